// File: rtl/spi_acl_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_acl_responder
// Description : SPI mode-3 slave that emulates a 3-axis accelerometer.
//               Decodes {RW, MB, ADDR[5:0]} command bytes and serves DEVID,
//               POWER_CTL, DATA_FORMAT and sign-extended 10-bit axis data.
//               Axis samples are snapshotted when SS falls, so a burst read
//               returns one coherent X/Y/Z set.
// Ports       : CLK, RST (async, active-low)
//               SCLK/SS/SDI in, SDO/SDO_OE out      - SPI pins
//               X_AXIS/Y_AXIS/Z_AXIS [9:0]          - two's-complement samples
//               POWER_CTL/DATA_FORMAT [7:0]         - writable registers
//               WR_VALID/WR_ADDR/WR_DATA            - committed-write strobe
// Revision    : 1.0 - initial release
// ============================================================================
module spi_acl_responder #(
    parameter logic [7:0] DEVID_VAL = 8'hE5,
    parameter logic [7:0] PWR_RST   = 8'h00,
    parameter logic [7:0] FMT_RST   = 8'h00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCLK,
    input  logic       SS,
    input  logic       SDI,
    output logic       SDO,
    output logic       SDO_OE,
    input  logic [9:0] X_AXIS,
    input  logic [9:0] Y_AXIS,
    input  logic [9:0] Z_AXIS,
    output logic [7:0] POWER_CTL,
    output logic [7:0] DATA_FORMAT,
    output logic       WR_VALID,
    output logic [5:0] WR_ADDR,
    output logic [7:0] WR_DATA
);

    localparam logic [5:0] ADDR_DEVID = 6'h00;
    localparam logic [5:0] ADDR_PWR   = 6'h2D;
    localparam logic [5:0] ADDR_FMT   = 6'h31;
    localparam logic [5:0] ADDR_X0    = 6'h32;
    localparam logic [5:0] ADDR_X1    = 6'h33;
    localparam logic [5:0] ADDR_Y0    = 6'h34;
    localparam logic [5:0] ADDR_Y1    = 6'h35;
    localparam logic [5:0] ADDR_Z0    = 6'h36;
    localparam logic [5:0] ADDR_Z1    = 6'h37;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Synchronisers: bits [1:0] are the 2-flop chain, bit [2] is the
    // previous synchronised value used for edge detection.
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] ss_sync_q,   ss_sync_d;
    logic [1:0] sdi_sync_q,  sdi_sync_d;

    state_t     state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] sr_q,        sr_d;
    logic       mb_q,        mb_d;
    logic       rw_q,        rw_d;
    logic [5:0] addr_q,      addr_d;
    logic [9:0] shx_q,       shx_d;
    logic [9:0] shy_q,       shy_d;
    logic [9:0] shz_q,       shz_d;
    logic       sdo_q,       sdo_d;
    logic       oe_q,        oe_d;
    logic       wr_valid_q,  wr_valid_d;
    logic [5:0] wr_addr_q,   wr_addr_d;
    logic [7:0] wr_data_q,   wr_data_d;
    logic [7:0] pwr_q,       pwr_d;
    logic [7:0] fmt_q,       fmt_d;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       ss_high;
    logic       ss_fall;
    logic       sdi_s;
    logic [7:0] shift_in;
    logic [5:0] next_addr;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_high   = ss_sync_q[1];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign sdi_s     = sdi_sync_q[1];

    // Byte as it stands once the current rising-edge bit is shifted in.
    assign shift_in  = {sr_q[6:0], sdi_s};
    // 6-bit add wraps 0x3F -> 0x00 naturally.
    assign next_addr = mb_q ? (addr_q + 6'd1) : addr_q;
    // The command byte supplies the first read address; afterwards the
    // prefetch targets the stepped address for the following byte.
    assign rd_addr   = (state_q == ST_CMD) ? shift_in[5:0] : next_addr;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_DEVID: rd_data = DEVID_VAL;
            ADDR_PWR:   rd_data = pwr_q;
            ADDR_FMT:   rd_data = fmt_q;
            ADDR_X0:    rd_data = shx_q[7:0];
            ADDR_X1:    rd_data = {{6{shx_q[9]}}, shx_q[9:8]};
            ADDR_Y0:    rd_data = shy_q[7:0];
            ADDR_Y1:    rd_data = {{6{shy_q[9]}}, shy_q[9:8]};
            ADDR_Z0:    rd_data = shz_q[7:0];
            ADDR_Z1:    rd_data = {{6{shz_q[9]}}, shz_q[9:8]};
            default:    rd_data = 8'h00;
        endcase
    end

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        ss_sync_d   = {ss_sync_q[1:0], SS};
        sdi_sync_d  = {sdi_sync_q[0], SDI};

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        mb_d        = mb_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        shx_d       = shx_q;
        shy_d       = shy_q;
        shz_d       = shz_q;
        sdo_d       = sdo_q;
        oe_d        = oe_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        pwr_d       = pwr_q;
        fmt_d       = fmt_q;

        case (state_q)
            ST_IDLE: begin
                sdo_d = 1'b1;
                oe_d  = 1'b0;
                if (ss_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = 3'd0;
                    shx_d     = X_AXIS;
                    shy_d     = Y_AXIS;
                    shz_d     = Z_AXIS;
                end
            end

            ST_CMD: begin
                // SS deassertion is checked first so it beats a
                // coincident 8th rising edge.
                if (ss_high) begin
                    state_d   = ST_IDLE;
                    sdo_d     = 1'b1;
                    oe_d      = 1'b0;
                    bit_cnt_d = 3'd0;
                end else if (sclk_rise) begin
                    sr_d      = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_d    = shift_in[7];
                        mb_d    = shift_in[6];
                        addr_d  = shift_in[5:0];
                        state_d = ST_DATA;
                        if (shift_in[7]) begin
                            sr_d = rd_data;
                            oe_d = 1'b1;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (ss_high) begin
                    state_d   = ST_IDLE;
                    sdo_d     = 1'b1;
                    oe_d      = 1'b0;
                    bit_cnt_d = 3'd0;
                end else if (rw_q) begin
                    if (sclk_fall) begin
                        sdo_d = sr_q[7];
                        sr_d  = {sr_q[6:0], 1'b0};
                    end else if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = next_addr;
                            sr_d   = rd_data;
                        end
                    end
                end else if (sclk_rise) begin
                    sr_d      = shift_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        // Every full byte is reported, even to read-only
                        // or unmapped addresses; only two regs change.
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = shift_in;
                        if (addr_q == ADDR_PWR) pwr_d = shift_in;
                        if (addr_q == ADDR_FMT) fmt_d = shift_in;
                        addr_d = next_addr;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                sdo_d   = 1'b1;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sclk_sync_q <= 3'b111;
            ss_sync_q   <= 3'b111;
            sdi_sync_q  <= 2'b11;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            sr_q        <= 8'h00;
            mb_q        <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= 6'd0;
            shx_q       <= 10'd0;
            shy_q       <= 10'd0;
            shz_q       <= 10'd0;
            sdo_q       <= 1'b1;
            oe_q        <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 6'd0;
            wr_data_q   <= 8'h00;
            pwr_q       <= PWR_RST;
            fmt_q       <= FMT_RST;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            mb_q        <= mb_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            shx_q       <= shx_d;
            shy_q       <= shy_d;
            shz_q       <= shz_d;
            sdo_q       <= sdo_d;
            oe_q        <= oe_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            pwr_q       <= pwr_d;
            fmt_q       <= fmt_d;
        end
    end

    assign SDO         = sdo_q;
    assign SDO_OE      = oe_q;
    assign POWER_CTL   = pwr_q;
    assign DATA_FORMAT = fmt_q;
    assign WR_VALID    = wr_valid_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_acl_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_acl_responder
// Description : Self-checking bench for spi_acl_responder. A transaction-level
//               model of the register map predicts MISO bytes, committed
//               writes and register state; directed cases pin literal values,
//               then randomized transactions exercise the rest.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_acl_responder;

    localparam int         H     = 8;       // SCLK half period in CLK cycles
    localparam logic [7:0] DEVID = 8'hE5;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       SCLK = 1'b1;
    logic       SS = 1'b1;
    logic       SDI = 1'b1;
    logic       SDO;
    logic       SDO_OE;
    logic [9:0] X_AXIS = 10'd0;
    logic [9:0] Y_AXIS = 10'd0;
    logic [9:0] Z_AXIS = 10'd0;
    logic [7:0] POWER_CTL;
    logic [7:0] DATA_FORMAT;
    logic       WR_VALID;
    logic [5:0] WR_ADDR;
    logic [7:0] WR_DATA;

    spi_acl_responder dut (
        .CLK         (CLK),
        .RST         (RST),
        .SCLK        (SCLK),
        .SS          (SS),
        .SDI         (SDI),
        .SDO         (SDO),
        .SDO_OE      (SDO_OE),
        .X_AXIS      (X_AXIS),
        .Y_AXIS      (Y_AXIS),
        .Z_AXIS      (Z_AXIS),
        .POWER_CTL   (POWER_CTL),
        .DATA_FORMAT (DATA_FORMAT),
        .WR_VALID    (WR_VALID),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [7:0]  m_pwr = 8'h00;
    logic [7:0]  m_fmt = 8'h00;
    logic [9:0]  m_sx, m_sy, m_sz;
    logic [13:0] exp_wr[$];

    bit          quiet  = 1'b0;
    bit          rd_win = 1'b0;
    bit          wr_win = 1'b0;
    logic [7:0]  rx   [0:15];
    logic [7:0]  wdat [0:15];
    int          wr_seen = 0;
    logic [5:0]  last_wa = 6'd0;
    logic [7:0]  last_wd = 8'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Axis byte from the two's-complement value viewed as a 16-bit integer.
    function automatic logic [7:0] axis_byte(input logic [9:0] v, input bit hi);
        int iv;
        iv = int'(v);
        if (iv >= 512) iv = iv - 1024;
        return hi ? iv[15:8] : iv[7:0];
    endfunction

    function automatic logic [7:0] m_read(input logic [5:0] a);
        case (a)
            6'h00:   return DEVID;
            6'h2D:   return m_pwr;
            6'h31:   return m_fmt;
            6'h32:   return axis_byte(m_sx, 1'b0);
            6'h33:   return axis_byte(m_sx, 1'b1);
            6'h34:   return axis_byte(m_sy, 1'b0);
            6'h35:   return axis_byte(m_sy, 1'b1);
            6'h36:   return axis_byte(m_sz, 1'b0);
            6'h37:   return axis_byte(m_sz, 1'b1);
            default: return 8'h00;
        endcase
    endfunction

    // Per-cycle compare process
    always @(negedge CLK) begin : cmp
        logic [13:0] e;
        if (RST) begin
            if (quiet) begin
                chk("idle_oe", {31'd0, SDO_OE}, 32'd0);
                chk("idle_sdo", {31'd0, SDO}, 32'd1);
                chk("power_ctl", {24'd0, POWER_CTL}, {24'd0, m_pwr});
                chk("data_format", {24'd0, DATA_FORMAT}, {24'd0, m_fmt});
            end
            if (rd_win) chk("read_oe", {31'd0, SDO_OE}, 32'd1);
            if (wr_win) chk("write_oe", {31'd0, SDO_OE}, 32'd0);
            if (WR_VALID) begin
                wr_seen++;
                last_wa = WR_ADDR;
                last_wd = WR_DATA;
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", {26'd0, WR_ADDR}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", {26'd0, WR_ADDR}, {26'd0, e[13:8]});
                    chk("wr_data", {24'd0, WR_DATA}, {24'd0, e[7:0]});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic s);
        SCLK = 1'b0;
        SDI  = b;
        tick(H);
        s    = SDO;
        SCLK = 1'b1;
        tick(H);
    endtask

    // One SPI transaction. abort_bits > 0 truncates the last byte to that many bits.
    task automatic xfer(input logic [7:0] cmd, input int nbytes, input int abort_bits,
                        input bit chg_x, input logic [9:0] new_x);
        logic       rw, mb, s;
        logic [5:0] a;
        logic [7:0] byt, e;
        int         nb;
        rw = cmd[7];
        mb = cmd[6];
        a  = cmd[5:0];
        quiet = 1'b0;
        m_sx = X_AXIS;
        m_sy = Y_AXIS;
        m_sz = Z_AXIS;
        SS = 1'b0;
        tick(H);
        wr_win = !rw;
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], s);
        if (rw) rd_win = 1'b1;
        for (int b = 0; b < nbytes; b++) begin
            nb = (b == nbytes - 1 && abort_bits > 0) ? abort_bits : 8;
            if (rw) begin
                e   = m_read(a);
                byt = 8'h00;
                for (int k = 0; k < nb; k++) begin
                    spi_bit(1'b1, s);
                    byt = {byt[6:0], s};
                end
                rx[b] = byt;
                if (nb == 8) chk("miso_byte", {24'd0, byt}, {24'd0, e});
            end else begin
                if (nb == 8) begin
                    exp_wr.push_back({a, wdat[b]});
                    if (a == 6'h2D) m_pwr = wdat[b];
                    if (a == 6'h31) m_fmt = wdat[b];
                end
                for (int k = 0; k < nb; k++) spi_bit(wdat[b][7-k], s);
            end
            a = mb ? a + 6'd1 : a;
            if (chg_x && b == 0) X_AXIS = new_x;
        end
        rd_win = 1'b0;
        wr_win = 1'b0;
        tick(H);
        SS = 1'b1;
        tick(10);
        chk("wr_pending", exp_wr.size(), 32'd0);
        exp_wr.delete();
        quiet = 1'b1;
        tick(2);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_sdo"}, {31'd0, SDO}, 32'd1);
        chk({tag, "_oe"}, {31'd0, SDO_OE}, 32'd0);
        chk({tag, "_wrv"}, {31'd0, WR_VALID}, 32'd0);
        chk({tag, "_wra"}, {26'd0, WR_ADDR}, 32'd0);
        chk({tag, "_wrd"}, {24'd0, WR_DATA}, 32'd0);
        chk({tag, "_pwr"}, {24'd0, POWER_CTL}, 32'h00);
        chk({tag, "_fmt"}, {24'd0, DATA_FORMAT}, 32'h00);
    endtask

    task automatic rst_mid_read();
        logic s;
        logic [7:0] cmd;
        cmd = 8'h80;
        quiet = 1'b0;
        SS = 1'b0;
        tick(H);
        for (int i = 7; i >= 0; i--) spi_bit(cmd[i], s);
        for (int k = 0; k < 3; k++) spi_bit(1'b1, s);
        RST = 1'b0;
        #1;
        chk_reset_vals("t7_rst");
        tick(2);
        chk_reset_vals("t7_rst_hold");
        SS  = 1'b1;
        RST = 1'b1;
        m_pwr = 8'h00;
        m_fmt = 8'h00;
        exp_wr.delete();
        tick(10);
        quiet = 1'b1;
    endtask

    logic [7:0] t3_exp [0:5];
    logic [5:0] addr_pick [0:11];

    initial begin
        logic [5:0] a;
        logic [7:0] cmd;
        int         nb, ab;

        t3_exp[0] = 8'hFF; t3_exp[1] = 8'h01; t3_exp[2] = 8'h00;
        t3_exp[3] = 8'hFE; t3_exp[4] = 8'h00; t3_exp[5] = 8'h00;
        addr_pick[0] = 6'h00; addr_pick[1]  = 6'h2D; addr_pick[2]  = 6'h31;
        addr_pick[3] = 6'h32; addr_pick[4]  = 6'h33; addr_pick[5]  = 6'h34;
        addr_pick[6] = 6'h35; addr_pick[7]  = 6'h36; addr_pick[8]  = 6'h37;
        addr_pick[9] = 6'h3F; addr_pick[10] = 6'h2C; addr_pick[11] = 6'h30;

        // Reset state
        RST = 1'b0;
        tick(4);
        chk_reset_vals("reset");
        RST = 1'b1;
        tick(4);
        quiet = 1'b1;

        // 1: DEVID read
        xfer(8'h80, 1, 0, 1'b0, 10'd0);
        chk("t1_devid", {24'd0, rx[0]}, 32'hE5);

        // 2: write POWER_CTL then read it back
        wdat[0] = 8'h08;
        wr_seen = 0;
        xfer(8'h2D, 1, 0, 1'b0, 10'd0);
        chk("t2_wr_count", wr_seen, 32'd1);
        chk("t2_wr_addr", {26'd0, last_wa}, 32'h2D);
        chk("t2_wr_data", {24'd0, last_wd}, 32'h08);
        chk("t2_pwr", {24'd0, POWER_CTL}, 32'h08);
        xfer(8'hAD, 1, 0, 1'b0, 10'd0);
        chk("t2_readback", {24'd0, rx[0]}, 32'h08);

        // 3: axis burst
        X_AXIS = 10'h1FF; Y_AXIS = 10'h200; Z_AXIS = 10'h000;
        tick(2);
        xfer(8'hF2, 6, 0, 1'b0, 10'd0);
        for (int i = 0; i < 6; i++) chk("t3_burst", {24'd0, rx[i]}, {24'd0, t3_exp[i]});

        // 4: snapshot holds mid-burst, next transaction sees new X
        xfer(8'hF2, 2, 0, 1'b1, 10'h001);
        chk("t4_x0_held", {24'd0, rx[0]}, 32'hFF);
        chk("t4_x1_held", {24'd0, rx[1]}, 32'h01);
        xfer(8'hF2, 2, 0, 1'b0, 10'd0);
        chk("t4_x0_new", {24'd0, rx[0]}, 32'h01);
        chk("t4_x1_new", {24'd0, rx[1]}, 32'h00);

        // 5: aborted write byte
        wdat[0] = 8'h5A;
        wr_seen = 0;
        xfer(8'h31, 1, 5, 1'b0, 10'd0);
        chk("t5_no_wr", wr_seen, 32'd0);
        chk("t5_fmt", {24'd0, DATA_FORMAT}, 32'h00);
        chk("t5_oe", {31'd0, SDO_OE}, 32'd0);

        // 6: address wrap and hold
        xfer(8'hFF, 2, 0, 1'b0, 10'd0);
        chk("t6_wrap0", {24'd0, rx[0]}, 32'h00);
        chk("t6_wrap1", {24'd0, rx[1]}, 32'hE5);
        xfer(8'h80, 2, 0, 1'b0, 10'd0);
        chk("t6_hold0", {24'd0, rx[0]}, 32'hE5);
        chk("t6_hold1", {24'd0, rx[1]}, 32'hE5);

        // 7: reset mid-read, then normal operation
        rst_mid_read();
        xfer(8'h80, 1, 0, 1'b0, 10'd0);
        chk("t7_devid", {24'd0, rx[0]}, 32'hE5);

        // Randomized transactions against the model
        for (int it = 0; it < 40; it++) begin
            X_AXIS = 10'($urandom);
            Y_AXIS = 10'($urandom);
            Z_AXIS = 10'($urandom);
            tick(2);
            if ($urandom_range(0, 3) == 0) a = 6'($urandom);
            else a = addr_pick[$urandom_range(0, 11)];
            cmd = {1'($urandom), 1'($urandom), a};
            nb  = $urandom_range(1, 4);
            ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            for (int i = 0; i < 16; i++) wdat[i] = 8'($urandom);
            xfer(cmd, nb, ab, ($urandom_range(0, 3) == 0), 10'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
